// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared constants and types for the stopwatch display stage:
//                digit width, active-low seven-segment glyphs, display state
//                encoding and the six-digit time bundle.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

  localparam int BCD_W = 4;

  // Segment patterns are active-low {dp,g,f,e,d,c,b,a}; dp is off in all glyphs
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Entry n is the glyph for digit n (entry 0 is the rightmost element)
  localparam logic [9:0][7:0] SEG_GLYPH = {
    8'h90,  // 9
    8'h80,  // 8
    8'hF8,  // 7
    8'h82,  // 6
    8'h92,  // 5
    8'h99,  // 4
    8'hB0,  // 3
    8'hA4,  // 2
    8'hF9,  // 1
    8'hC0   // 0
  };

  typedef enum logic [0:0] {
    ST_LIVE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Full time value as delivered by the stopwatch counter chain
  typedef struct packed {
    logic [BCD_W-1:0] min1;
    logic [BCD_W-1:0] min0;
    logic [BCD_W-1:0] sec1;
    logic [BCD_W-1:0] sec0;
    logic [BCD_W-1:0] small_sec1;
    logic [BCD_W-1:0] small_sec0;
  } digits_t;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_display_if
//  Description : Connection between the stopwatch counter chain (master) and
//                the display stage (slave): BCD digits, page select, lap
//                request, and the multiplexed display drive.
//  Revision    : 1.0  initial release
// ============================================================================
interface stopwatch_display_if;
  import stopwatch_pkg::*;

  logic [BCD_W-1:0] small_sec0;
  logic [BCD_W-1:0] small_sec1;
  logic [BCD_W-1:0] sec0;
  logic [BCD_W-1:0] sec1;
  logic [BCD_W-1:0] min0;
  logic [BCD_W-1:0] min1;
  logic             show_min;
  logic             hold_pulse;
  logic             held;
  logic [3:0]       anode;
  logic [7:0]       segs;

  modport master (
    output small_sec0, small_sec1, sec0, sec1, min0, min1,
    output show_min, hold_pulse,
    input  held, anode, segs
  );

  modport slave (
    input  small_sec0, small_sec1, sec0, sec1, min0, min1,
    input  show_min, hold_pulse,
    output held, anode, segs
  );

endinterface : stopwatch_display_if
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg
//  Description : Combinational BCD to active-low seven-segment decoder with
//                decimal point. Codes 10..15 render as a dash.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             dp,    // 1 lights the decimal point
  output logic [7:0]       segs
);

  logic [7:0] glyph;

  // Look up the glyph, falling back to a dash for non-decimal codes
  always_comb begin
    glyph = SEG_DASH;
    if (bcd <= 4'd9) begin
      glyph = SEG_GLYPH[bcd];
    end
    segs = {glyph[7] & ~dp, glyph[6:0]};
  end

endmodule : bcd_to_seg
`default_nettype wire

// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_display
//  Description : Four-digit multiplexed common-anode display driver for the
//                stopwatch. Selects a minutes or seconds page, freezes a lap
//                value on request, and scans the digits from a free-running
//                counter. All outputs are registered.
//  Options     : LEADING_ZERO_BLANK_EN - blank the leftmost digit when it is 0
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_CNT_W = 18   // digit index is the top two bits; min 3
) (
  input  logic               clk,
  input  logic               rst,
  stopwatch_display_if.slave bus
);

  logic [SCAN_CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  state_t                state_q, state_d;
  digits_t               hold_q, hold_d;
  logic                  held_q, held_d;
  logic [3:0]            anode_q, anode_d;
  logic [7:0]            segs_q, segs_d;

  logic                  capture_en;
  digits_t               live;
  digits_t               src;
  logic [1:0]            idx;
  logic [BCD_W-1:0]      digit_val;
  logic                  digit_dp;
  logic [7:0]            glyph;

  // Gather the live inputs into one bundle so live and held share one mux
  always_comb begin
    live.min1       = bus.min1;
    live.min0       = bus.min0;
    live.sec1       = bus.sec1;
    live.sec0       = bus.sec0;
    live.small_sec1 = bus.small_sec1;
    live.small_sec0 = bus.small_sec0;
  end

  // Free-running scan counter; wraps naturally at all-ones
  always_comb begin
    scan_cnt_d = scan_cnt_q + {{(SCAN_CNT_W-1){1'b0}}, 1'b1};
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LIVE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: every lap pulse toggles between live and hold
  always_comb begin
    state_d = state_q;
    if (bus.hold_pulse) begin
      state_d = (state_q == ST_LIVE) ? ST_HOLD : ST_LIVE;
    end
  end

  // FSM outputs: capture only on entry to hold; held indicator tracks state
  always_comb begin
    capture_en = (state_q == ST_LIVE) && bus.hold_pulse;
    held_d     = (state_q == ST_HOLD);
  end

  // Hold registers keep the lap value until the next capture
  always_comb begin
    hold_d = capture_en ? live : hold_q;
  end

  // Page mux: pick the source, then the digit for the current scan slot
  always_comb begin
    src       = (state_q == ST_HOLD) ? hold_q : live;
    idx       = scan_cnt_q[SCAN_CNT_W-1 -: 2];
    digit_val = '0;
    digit_dp  = (idx == 2'd2);
    if (bus.show_min) begin
      case (idx)
        2'd3:    digit_val = src.min1;
        2'd2:    digit_val = src.min0;
        2'd1:    digit_val = src.sec1;
        default: digit_val = src.sec0;
      endcase
    end else begin
      case (idx)
        2'd3:    digit_val = src.sec1;
        2'd2:    digit_val = src.sec0;
        2'd1:    digit_val = src.small_sec1;
        default: digit_val = src.small_sec0;
      endcase
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd  (digit_val),
    .dp   (digit_dp),
    .segs (glyph)
  );

  // Next display drive: one active-low anode, glyph with optional blanking
  always_comb begin
    anode_d = ~(4'b0001 << idx);
    segs_d  = glyph;
`ifdef LEADING_ZERO_BLANK_EN
    // Only the leftmost digit blanks; index 2 carries the separator dp
    if ((idx == 2'd3) && (digit_val == '0)) begin
      segs_d = SEG_BLANK;
    end
`endif
  end

  // State-holding registers other than the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      hold_q     <= '0;
      held_q     <= 1'b0;
      anode_q    <= 4'b1111;
      segs_q     <= SEG_BLANK;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      hold_q     <= hold_d;
      held_q     <= held_d;
      anode_q    <= anode_d;
      segs_q     <= segs_d;
    end
  end

  assign bus.held  = held_q;
  assign bus.anode = anode_q;
  assign bus.segs  = segs_q;

endmodule : stopwatch_display
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_display
//  Description : Self-checking bench for stopwatch_display. A cycle model
//                pushes the expected display drive on every active edge and
//                a checker pops and compares on the falling edge.
//                Honours LEADING_ZERO_BLANK_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_display;

  localparam int TW = 4;  // 4 clocks per digit, 16-clock refresh

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  stopwatch_display_if u_if ();

  stopwatch_display #(.SCAN_CNT_W(TW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Active-high gfedcba glyphs, dash for non-decimal codes
  function automatic logic [6:0] glyph_ah(input logic [3:0] v);
    case (v)
      4'd0: glyph_ah = 7'h3F;
      4'd1: glyph_ah = 7'h06;
      4'd2: glyph_ah = 7'h5B;
      4'd3: glyph_ah = 7'h4F;
      4'd4: glyph_ah = 7'h66;
      4'd5: glyph_ah = 7'h6D;
      4'd6: glyph_ah = 7'h7D;
      4'd7: glyph_ah = 7'h07;
      4'd8: glyph_ah = 7'h7F;
      4'd9: glyph_ah = 7'h6F;
      default: glyph_ah = 7'h40;
    endcase
  endfunction

  typedef struct {
    logic [3:0] anode;
    logic [7:0] segs;
    logic       held;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  // {min1,min0,sec1,sec0,small1,small0}
  function automatic logic [23:0] live_vec();
    return {u_if.min1, u_if.min0, u_if.sec1, u_if.sec0, u_if.small_sec1, u_if.small_sec0};
  endfunction

  function automatic exp_t model_out(input logic [1:0] idx, input logic [23:0] v,
                                     input logic smin, input logic hold);
    exp_t       r;
    logic [3:0] d;
    if (smin) d = v[23 - 4*(3 - idx) -: 4];   // idx3=min1 .. idx0=sec0
    else      d = v[15 - 4*(3 - idx) -: 4];   // idx3=sec1 .. idx0=small0
    r.anode = 4'b1111;
    r.anode[idx] = 1'b0;
    r.segs  = ~{(idx == 2'd2), glyph_ah(d)};
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 2'd3 && d == 4'd0) r.segs = 8'hFF;
`endif
    r.held = hold;
    return r;
  endfunction

  logic [TW-1:0] m_scan = '0;
  logic          m_hold = 1'b0;
  logic [23:0]   m_h    = '0;

  // Reference model: expected drive for this edge, then advance model state
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_scan <= '0;
      m_hold <= 1'b0;
      m_h    <= '0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_out(m_scan[TW-1 -: 2], m_hold ? m_h : live_vec(),
                                u_if.show_min, m_hold));
      if (u_if.hold_pulse) begin
        if (!m_hold) m_h <= live_vec();
        m_hold <= ~m_hold;
      end
      m_scan <= m_scan + 1'b1;
    end
  end

  // Scoreboard checker on the falling edge
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("anode", {28'd0, u_if.anode}, {28'd0, e.anode});
      check("segs",  {24'd0, u_if.segs},  {24'd0, e.segs});
      check("held",  {31'd0, u_if.held},  {31'd0, e.held});
    end
  end

  task automatic set_time(input logic [3:0] m1, m0, s1, s0, f1, f0);
    u_if.min1 = m1; u_if.min0 = m0; u_if.sec1 = s1;
    u_if.sec0 = s0; u_if.small_sec1 = f1; u_if.small_sec0 = f0;
  endtask

  task automatic lap_pulse();
    u_if.hold_pulse = 1'b1;
    @(negedge clk);
    u_if.hold_pulse = 1'b0;
  endtask

  initial begin
    u_if.show_min   = 1'b1;
    u_if.hold_pulse = 1'b0;
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    #2 rst = 1'b1;
    #1;
    check("rst_anode", {28'd0, u_if.anode}, 32'hF);
    check("rst_segs",  {24'd0, u_if.segs},  32'hFF);
    check("rst_held",  {31'd0, u_if.held},  32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Minutes page: index 0 first, then index 1, then index 2 with dp
    @(negedge clk);
    check("first_anode", {28'd0, u_if.anode}, 32'hE);
    check("first_segs",  {24'd0, u_if.segs},  32'h99);
    repeat (4) @(negedge clk);
    check("idx1_anode", {28'd0, u_if.anode}, 32'hD);
    check("idx1_segs",  {24'd0, u_if.segs},  32'hB0);
    repeat (4) @(negedge clk);
    check("idx2_anode", {28'd0, u_if.anode}, 32'hB);
    check("idx2_segs",  {24'd0, u_if.segs},  32'h24);
    repeat (24) @(negedge clk);

    // Seconds page
    u_if.show_min = 1'b0;
    repeat (32) @(negedge clk);

    // Lap freeze at sec=07 while the inputs advance to 09
    set_time(4'd0, 4'd1, 4'd0, 4'd7, 4'd2, 4'd3);
    repeat (3) @(negedge clk);
    lap_pulse();
    set_time(4'd0, 4'd1, 4'd0, 4'd9, 4'd4, 4'd5);
    repeat (32) @(negedge clk);
    lap_pulse();
    repeat (32) @(negedge clk);

    // Back-to-back pulses: values come from the first one
    lap_pulse();
    set_time(4'd0, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0);
    lap_pulse();
    repeat (20) @(negedge clk);

    // Invalid code renders a dash; then leading zero on the minutes page
    u_if.sec0 = 4'hC;
    repeat (20) @(negedge clk);
    u_if.show_min = 1'b1;
    set_time(4'd0, 4'd5, 4'd4, 4'hC, 4'd0, 4'd0);
    repeat (20) @(negedge clk);

    // Asynchronous reset while holding; lap pulse during reset is ignored
    lap_pulse();
    repeat (6) @(negedge clk);
    check("pre_rst_held", {31'd0, u_if.held}, 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    u_if.hold_pulse = 1'b1;
    #1;
    check("arst_anode", {28'd0, u_if.anode}, 32'hF);
    check("arst_segs",  {24'd0, u_if.segs},  32'hFF);
    check("arst_held",  {31'd0, u_if.held},  32'h0);
    repeat (2) @(negedge clk);
    u_if.hold_pulse = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Random traffic with occasional laps and page flips
    repeat (150) begin
      set_time(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) u_if.show_min = ~u_if.show_min;
      u_if.hold_pulse = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    u_if.hold_pulse = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_stopwatch_display
`default_nettype wire
